line_stream_buffer: RTL and testbench

- Accepts full memory lines (512-bit read beats), unpacks a selected contiguous range of fixed-width elements, and queues them in an internal show-ahead FIFO.
- Sits between the AXI read-data channel and the compute logic; one instance per streamed array (vertex pairs, in-edge indices).
- Replaces the separate line-unpacker + FIFO pair with one handshaked block.

---
 rtl/line_stream_buffer.sv | 214 +++++++++++++++++++++
 tb/tb_line_stream_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_stream_buffer.sv
// line_stream_buffer
//   Accepts one memory line at a time, unpacks the contiguous element range
//   [line_base, min(line_bounds, N)) in MSB-first order (element 0 is the top
//   WIDTH bits), and queues the elements in a show-ahead FIFO of
//   2^LOG_DEPTH entries.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   line_valid           line_data/line_base/line_bounds are valid this cycle
//   line_data            FULL_WIDTH-bit memory line
//   line_base            first element index to emit
//   line_bounds          exclusive end index (clamped to N)
//   line_ready           unpacker idle; line taken on line_valid & line_ready
//   rd_req               pop the FIFO head (ignored while empty)
//   q                    FIFO head, 0 while empty
//   empty, full, count   FIFO status and occupancy
//
// Optional build macro LINE_STREAM_DIRECT_SEL_EN adds:
//   sel_idx              element index into the live line_data
//   sel_data             element sel_idx of line_data when line_valid, else 0
//                        (0 for sel_idx >= N); bypasses the FIFO entirely

module line_stream_buffer #(
  parameter int FULL_WIDTH = 512,
  parameter int WIDTH      = 64,
  parameter int LOG_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_valid,
  input  logic [FULL_WIDTH-1:0] line_data,
  input  logic [7:0]            line_base,
  input  logic [7:0]            line_bounds,
  output logic                  line_ready,
  input  logic                  rd_req,
  output logic [WIDTH-1:0]      q,
  output logic                  empty,
  output logic                  full,
  output logic [LOG_DEPTH:0]    count
`ifdef LINE_STREAM_DIRECT_SEL_EN
  ,
  input  logic [7:0]            sel_idx,
  output logic [WIDTH-1:0]      sel_data
`endif
);

  localparam int N     = FULL_WIDTH / WIDTH;
  localparam int DEPTH = 1 << LOG_DEPTH;
  // Only used when N fits in the 8-bit index space; wider lines never clamp.
  localparam logic [7:0]           N8       = 8'(N);
  localparam logic [LOG_DEPTH-1:0] PTR_ONE  = LOG_DEPTH'(1);
  localparam logic [LOG_DEPTH:0]   CNT_ONE  = (LOG_DEPTH+1)'(1);
  localparam logic [LOG_DEPTH:0]   CNT_FULL = {1'b1, {LOG_DEPTH{1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Element idx of a line, MSB-first; indices outside the line read as 0.
  function automatic logic [WIDTH-1:0] get_elem(input logic [FULL_WIDTH-1:0] l,
                                                input logic [7:0]            idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r = (int'(idx) == i) ? l[FULL_WIDTH-1-i*WIDTH -: WIDTH] : r;
    end
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [FULL_WIDTH-1:0] line_q, line_d;
  logic [7:0]            cur_q, cur_d;
  logic [7:0]            end_q, end_d;
  logic [LOG_DEPTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]    count_q, count_d;
  logic [WIDTH-1:0]      mem_q [DEPTH];

  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic [WIDTH-1:0]      push_data_s;
  logic [7:0]            clamp_end_s;

  assign full_s  = (count_q == CNT_FULL);
  assign empty_s = (count_q == '0);
  // Push and pop gates both look at pre-edge occupancy, so a pop never makes
  // room for a push in the same cycle when the FIFO is full.
  assign push_s  = (state_q == ST_EMIT) && !full_s;
  assign pop_s   = rd_req && !empty_s;
  assign push_data_s = get_elem(line_q, cur_q);

  // Clamp the exclusive end index to the number of elements in a line.
  always_comb begin
    clamp_end_s = line_bounds;
    if (N < 256 && int'(line_bounds) > N) begin
      clamp_end_s = N8;
    end else begin
      clamp_end_s = line_bounds;
    end
  end

  // Unpacker next-state: capture a line in IDLE, walk cur towards end in EMIT.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    cur_d   = cur_q;
    end_d   = end_q;
    case (state_q)
      ST_IDLE: begin
        if (line_valid) begin
          line_d = line_data;
          cur_d  = line_base;
          end_d  = clamp_end_s;
          // An empty or out-of-range span is consumed without output.
          if (clamp_end_s > line_base) begin
            state_d = ST_EMIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (push_s) begin
          cur_d = cur_q + 8'd1;
          // cur < end <= 255 here, so cur + 1 cannot wrap.
          if ((cur_q + 8'd1) == end_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_EMIT;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control and line registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      line_q   <= '0;
      cur_q    <= 8'd0;
      end_q    <= 8'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      cur_q    <= cur_d;
      end_q    <= end_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents need no reset because q is masked while empty.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_q[wr_ptr_q] <= push_data_s;
    end
  end

  assign line_ready = (state_q == ST_IDLE);
  assign empty      = empty_s;
  assign full       = full_s;
  assign count      = count_q;
  assign q          = empty_s ? '0 : mem_q[rd_ptr_q];

`ifdef LINE_STREAM_DIRECT_SEL_EN
  // Direct element select on the live input line.
  always_comb begin
    sel_data = '0;
    if (line_valid) begin
      sel_data = get_elem(line_data, sel_idx);
    end else begin
      sel_data = '0;
    end
  end
`endif

endmodule

// File: tb/tb_line_stream_buffer.sv
// Self-checking bench for line_stream_buffer (FULL_WIDTH=512, WIDTH=64,
// LOG_DEPTH=2). A queue-level model tracks the elements still to be emitted
// and the FIFO contents; every negedge the DUT outputs are compared to it.

module tb_line_stream_buffer;

  localparam int FW    = 512;
  localparam int W     = 64;
  localparam int LD    = 2;
  localparam int N     = FW / W;
  localparam int DEPTH = 1 << LD;

  logic          clk;
  logic          rst;
  logic          line_valid;
  logic [FW-1:0] line_data;
  logic [7:0]    line_base;
  logic [7:0]    line_bounds;
  logic          line_ready;
  logic          rd_req;
  logic [W-1:0]  q;
  logic          empty;
  logic          full;
  logic [LD:0]   count;
`ifdef LINE_STREAM_DIRECT_SEL_EN
  logic [7:0]    sel_idx;
  logic [W-1:0]  sel_data;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  line_stream_buffer #(.FULL_WIDTH(FW), .WIDTH(W), .LOG_DEPTH(LD)) dut (
    .clk(clk), .rst(rst),
    .line_valid(line_valid), .line_data(line_data),
    .line_base(line_base), .line_bounds(line_bounds),
    .line_ready(line_ready),
    .rd_req(rd_req), .q(q), .empty(empty), .full(full), .count(count)
`ifdef LINE_STREAM_DIRECT_SEL_EN
    , .sel_idx(sel_idx), .sel_data(sel_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] elem_of(input logic [FW-1:0] l, input int i);
    return l[FW-1-i*W -: W];
  endfunction

  // Line whose element i (MSB-first) is start+i.
  function automatic logic [FW-1:0] mk_line(input logic [W-1:0] start);
    logic [FW-1:0] l;
    l = '0;
    for (int i = 0; i < N; i++) l[FW-1-i*W -: W] = start + W'(i);
    return l;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: elements waiting to be emitted, and FIFO contents.
  logic [W-1:0] m_pend[$];
  logic [W-1:0] m_fifo[$];

  always @(posedge clk) begin
    bit           idle, dpush, dpop;
    int           sz, hi;
    logic [W-1:0] pv;
    if (rst) begin
      m_pend.delete();
      m_fifo.delete();
    end else begin
      idle  = (m_pend.size() == 0);
      sz    = m_fifo.size();
      dpush = !idle && (sz < DEPTH);
      dpop  = rd_req && (sz > 0);
      pv    = '0;
      if (dpush) pv = m_pend.pop_front();
      if (dpop) void'(m_fifo.pop_front());
      if (dpush) m_fifo.push_back(pv);
      if (idle && line_valid) begin
        hi = (int'(line_bounds) < N) ? int'(line_bounds) : N;
        for (int i = int'(line_base); i < hi; i++) m_pend.push_back(elem_of(line_data, i));
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic [W-1:0] eq;
    if (chk_en) begin
      eq = (m_fifo.size() > 0) ? m_fifo[0] : '0;
      chk("line_ready", W'(line_ready), W'(m_pend.size() == 0));
      chk("empty",      W'(empty),      W'(m_fifo.size() == 0));
      chk("full",       W'(full),       W'(m_fifo.size() == DEPTH));
      chk("count",      W'(count),      W'(m_fifo.size()));
      chk("q",          q,              eq);
`ifdef LINE_STREAM_DIRECT_SEL_EN
      chk("sel_data", sel_data,
          (line_valid && sel_idx < N) ? elem_of(line_data, int'(sel_idx)) : '0);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a line until it is accepted (bounded wait).
  task automatic send_line(input logic [FW-1:0] d, input logic [7:0] b, input logic [7:0] e);
    int guard;
    guard = 0;
    while (!line_ready && guard < 200) begin
      tick(1);
      guard++;
    end
    if (guard >= 200) begin
      errors++;
      $display("FAIL send_line_timeout: got line_ready=0 expected 1 within 200 cycles");
    end
    line_valid  = 1'b1;
    line_data   = d;
    line_base   = b;
    line_bounds = e;
    tick(1);
    line_valid = 1'b0;
  endtask

  initial begin
    bit rdy;
    rst = 1'b1; line_valid = 1'b0; line_data = '0;
    line_base = 8'd0; line_bounds = 8'd0; rd_req = 1'b0;
`ifdef LINE_STREAM_DIRECT_SEL_EN
    sel_idx = 8'd0;
`endif
    tick(2);
    chk_en = 1'b1;
    chk("rst_line_ready", W'(line_ready), 64'd1);
    chk("rst_empty", W'(empty), 64'd1);
    chk("rst_count", W'(count), 64'd0);
    chk("rst_q", q, 64'd0);
    rst = 1'b0;
    tick(1);

    // Partial range 3..7 of 0x10..0x17.
    send_line(mk_line(64'h10), 8'd3, 8'd8);
    tick(5);
    chk("range_count", W'(count), 64'd4);
    chk("range_full", W'(full), 64'd1);
    chk("range_head", q, 64'h13);
    rd_req = 1'b1;
    tick(8);
    rd_req = 1'b0;
    chk("range_drained_empty", W'(empty), 64'd1);
    chk("range_drained_q", q, 64'd0);

`ifdef LINE_STREAM_DIRECT_SEL_EN
    line_valid = 1'b1; line_data = mk_line(64'h10); sel_idx = 8'd2;
    #1 chk("sel_idx2", sel_data, 64'h12);
    sel_idx = 8'd9;
    #1 chk("sel_idx9", sel_data, 64'd0);
    line_valid = 1'b0; sel_idx = 8'd0;
    tick(1);
`endif

    // Backpressure: two full lines, no pops, then drain one per cycle.
    send_line(mk_line(64'h20), 8'd0, 8'd8);
    line_valid = 1'b1; line_data = mk_line(64'h30); line_base = 8'd0; line_bounds = 8'd8;
    tick(8);
    chk("bp_full", W'(full), 64'd1);
    chk("bp_count", W'(count), 64'd4);
    chk("bp_line_ready", W'(line_ready), 64'd0);
    chk("bp_head", q, 64'h20);
    rd_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rdy = line_ready;
      tick(1);
      if (rdy) line_valid = 1'b0;
    end
    rd_req = 1'b0;
    chk("bp_drained", W'(empty), 64'd1);

    // Simultaneous push and pop keep occupancy steady.
    send_line(mk_line(64'h40), 8'd0, 8'd8);
    tick(2);
    rd_req = 1'b1;
    tick(3);
    chk("pp_count", W'(count), 64'd2);
    chk("pp_head", q, 64'h43);
    tick(10);
    rd_req = 1'b0;
    chk("pp_empty", W'(empty), 64'd1);
    rd_req = 1'b1;
    tick(2);
    rd_req = 1'b0;
    chk("underflow_count", W'(count), 64'd0);

    // Degenerate ranges.
    send_line(mk_line(64'h50), 8'd0, 8'd0);
    send_line(mk_line(64'h50), 8'd5, 8'd5);
    send_line(mk_line(64'h50), 8'd9, 8'd20);
    tick(2);
    chk("degen_count", W'(count), 64'd0);
    chk("degen_ready", W'(line_ready), 64'd1);
    send_line(mk_line(64'h60), 8'd6, 8'd20);
    tick(3);
    chk("clamp_count", W'(count), 64'd2);
    chk("clamp_head", q, 64'h66);
    rd_req = 1'b1;
    tick(3);
    rd_req = 1'b0;

    // Reset in the middle of emitting a line.
    send_line(mk_line(64'h70), 8'd0, 8'd8);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("midrst_empty", W'(empty), 64'd1);
    chk("midrst_ready", W'(line_ready), 64'd1);
    rst = 1'b0;
    tick(3);
    chk("midrst_count", W'(count), 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      line_valid  = ($urandom % 3) == 0;
      for (int k = 0; k < FW / 32; k++) line_data[k*32 +: 32] = $urandom;
      line_base   = 8'($urandom_range(0, 10));
      line_bounds = 8'($urandom_range(0, 12));
      rd_req      = ($urandom % 2) == 0;
      rst         = ($urandom % 250) == 0;
`ifdef LINE_STREAM_DIRECT_SEL_EN
      sel_idx     = 8'($urandom_range(0, 10));
`endif
      tick(1);
    end
    line_valid = 1'b0; rd_req = 1'b0; rst = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
